// File: rtl/cp0.sv
// cp0: Coprocessor-0 exception controller for the five-stage MIPS pipeline.
//
// Sits beside the M stage and holds SR (12), Cause (13), EPC (14) and PRId (15).
// Each cycle it combines enabled hardware interrupts with the exception code of
// the M-stage instruction. The result is Req, which flushes the pipeline and
// redirects fetch to the handler. EPC, Cause and SR.EXL are captured on the same
// edge that performs the flush. eret (EXLClr) releases the exception state.
//
// Handshake note: there is no valid/ready pairing here. Req is a single-cycle
// combinational strobe. The pipeline acts on it at the next posedge, and this
// block commits its own state on that same posedge, so no acknowledge is needed.
//
// Configuration macro: CP0_BD_EN
//   defined   -> branch-delay tracking: EPC = M_pc-4 and Cause.BD = M_bd
//                when the faulting instruction sits in a delay slot.
//   undefined -> M_bd is ignored, EPC = M_pc always, and Cause[31] reads 0.

module cp0 #(
    parameter logic [31:0] PRID_VAL   = 32'h2021_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        we,
    input  logic [31:0] M_pc,
    input  logic        M_bd,
    input  logic [4:0]  M_exccode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] Dout,
    output logic [31:0] EPC_out,
    output logic        Req
);

    // Register numbers as seen by mfc0/mtc0.
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR fields: only IM, EXL and IE are stored.
    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;

    // Cause fields: BD, IP and ExcCode.
    logic        bd_q,      bd_d;
    logic [5:0]  ip_q,      ip_d;
    logic [4:0]  exccode_q, exccode_d;

    // Exception program counter.
    logic [31:0] epc_q, epc_d;

    // Request terms.
    logic        int_req;
    logic        exc_req;

    // Values captured on an exception edge. They depend on the BD build option.
    logic [31:0] epc_capture;
    logic        bd_capture;

`ifdef CP0_BD_EN
    // A faulting delay-slot instruction must restart at its branch.
    assign epc_capture = M_bd ? (M_pc - 32'd4) : M_pc;
    assign bd_capture  = M_bd;

    // HANDLER_PC only documents the vector; the pipeline registers own it.
    logic unused_cfg;
    assign unused_cfg = ^HANDLER_PC;
`else
    // Without delay-slot tracking, always restart at the faulting instruction.
    assign epc_capture = M_pc;
    assign bd_capture  = 1'b0;

    // M_bd has no effect in this build. HANDLER_PC is informational only.
    logic unused_cfg;
    assign unused_cfg = ^{HANDLER_PC, M_bd};
`endif

    // Interrupt and exception qualification.
    // EXL masks both sources, and reset forces Req low.
    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (M_exccode != 5'd0) & ~exl_q;
    assign Req     = (int_req | exc_req) & ~reset;

    // Next-state logic.
    // An exception capture has priority over mtc0. EXLClr overrides any SR write
    // to the EXL bit. IP samples HWInt on every edge.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;

        if (Req) begin
            exl_d     = 1'b1;
            exccode_d = int_req ? 5'd0 : M_exccode;
            bd_d      = bd_capture;
            epc_d     = epc_capture;
        end else begin
            if (we) begin
                case (A2)
                    REG_SR: begin
                        im_d  = Din[15:10];
                        exl_d = Din[1];
                        ie_d  = Din[0];
                    end
                    REG_EPC: begin
                        epc_d = Din;
                    end
                    default: begin
                        // Cause, PRId and unimplemented numbers are read-only.
                    end
                endcase
            end
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    // mfc0 read port. It is purely combinational on A1 and shows registered
    // state only, with no bypass from a same-cycle write.
    always_comb begin
        Dout = 32'd0;
        case (A1)
            REG_SR:    Dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
            REG_CAUSE: Dout = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
            REG_EPC:   Dout = epc_q;
            REG_PRID:  Dout = PRID_VAL;
            default:   Dout = 32'd0;
        endcase
    end

    assign EPC_out = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Testbench for cp0. It uses directed scenarios from the block's test plan plus
// randomized traffic. Expected values come from a register-level reference model.
module tb_cp0;

    localparam logic [31:0] PRID = 32'h2021_0007;

    // ---------------- clock / reset block ----------------
    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        we;
    logic [31:0] M_pc;
    logic        M_bd;
    logic [4:0]  M_exccode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] Dout;
    logic [31:0] EPC_out;
    logic        Req;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cp0 #(.PRID_VAL(PRID), .HANDLER_PC(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .we(we),
        .M_pc(M_pc), .M_bd(M_bd), .M_exccode(M_exccode), .HWInt(HWInt),
        .EXLClr(EXLClr), .Dout(Dout), .EPC_out(EPC_out), .Req(Req)
    );

    // ---------------- reference model ----------------
    // Architectural view of each register as the software would read it.
    logic [31:0] m_sr    = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic [31:0] m_epc   = 32'd0;

    function automatic logic model_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        if (reset) return 1'b0;
        return model_int() || ((M_exccode != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        reset = 1'b0; A1 = 5'd0; A2 = 5'd0; Din = 32'd0; we = 1'b0;
        M_pc = 32'h0000_3000; M_bd = 1'b0; M_exccode = 5'd0; HWInt = 6'd0;
        EXLClr = 1'b0;
    endtask

    // Advance one clock. The model computes the post-edge architectural state
    // from the inputs present during this cycle.
    task automatic tick();
        logic [31:0] n_sr, n_cause, n_epc;
        logic        bd;
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
`ifdef CP0_BD_EN
        bd = M_bd;
`else
        bd = 1'b0;
`endif
        if (reset) begin
            n_sr = 32'd0; n_cause = 32'd0; n_epc = 32'd0;
        end else if (model_req()) begin
            n_sr    = m_sr | 32'h2;
            n_cause = {bd, 15'd0, HWInt, 3'd0,
                       (model_int() ? 5'd0 : M_exccode), 2'd0};
            n_epc   = bd ? M_pc - 32'd4 : M_pc;
        end else begin
            if (we && A2 == 5'd12) n_sr  = Din & 32'h0000_FC03;
            if (we && A2 == 5'd14) n_epc = Din;
            if (EXLClr) n_sr = n_sr & ~32'h2;
            n_cause[15:10] = HWInt;
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        #1;
    endtask

    // Issue one mtc0 write, then drop we.
    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; A2 = a; Din = d;
        tick();
        we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] exp_q[$];
        reset = 1'b1; M_exccode = 5'd4;
        #1;
        checks++;
        if (Req !== 1'b0) begin
            errors++; $display("FAIL reset_req_forced: got %b want 0", Req);
        end
        tick();
        checks++;
        if (Req !== 1'b0) begin
            errors++; $display("FAIL reset_req_hold: got %b want 0", Req);
        end
        reset = 1'b0; M_exccode = 5'd0;
        exp_q = '{32'd0, 32'd0, 32'd0, PRID};
        for (int i = 0; i < 4; i++) begin
            A1 = 5'(12 + i);
            #1;
            checks++;
            if (Dout !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_read_%0d: got %h want %h", 12 + i, Dout, exp_q[i]);
            end
        end
        checks++;
        if (EPC_out !== 32'd0) begin
            errors++; $display("FAIL reset_epc_out: got %h want 0", EPC_out);
        end
    endtask

    task automatic test_sr_exl_clear();
        HWInt = 6'b000001;
        mtc0(5'd12, 32'hFFFF_FFFF);
        A1 = 5'd12;
        #1;
        checks++;
        if (Dout !== 32'h0000_FC03) begin
            errors++; $display("FAIL sr_mask: got %h want 0000fc03", Dout);
        end
        checks++;
        if (Req !== 1'b0) begin
            errors++; $display("FAIL exl_masks_int: got %b want 0", Req);
        end
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; M_pc = 32'h0000_3000;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            errors++; $display("FAIL int_after_eret: got %b want 1", Req);
        end
        tick();
        A1 = 5'd13;
        #1;
        checks++;
        if (Dout[6:2] !== 5'd0) begin
            errors++; $display("FAIL int_exccode: got %0d want 0", Dout[6:2]);
        end
        checks++;
        if (EPC_out !== 32'h0000_3000) begin
            errors++; $display("FAIL int_epc: got %h want 00003000", EPC_out);
        end
        HWInt = 6'd0;
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_int_priority();
        mtc0(5'd12, 32'h0000_0401);
        M_exccode = 5'd12; HWInt = 6'b000001; M_pc = 32'h0000_3010;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            errors++; $display("FAIL prio_req: got %b want 1", Req);
        end
        tick();
        M_exccode = 5'd0; HWInt = 6'd0; A1 = 5'd13;
        #1;
        checks++;
        if (Dout[6:2] !== 5'd0) begin
            errors++; $display("FAIL prio_exccode: got %0d want 0", Dout[6:2]);
        end
        A1 = 5'd14;
        #1;
        checks++;
        if (Dout !== 32'h0000_3010) begin
            errors++; $display("FAIL prio_epc: got %h want 00003010", Dout);
        end
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_branch_delay();
        logic [31:0] exp_epc;
        logic        exp_bd;
`ifdef CP0_BD_EN
        exp_epc = 32'h0000_3004; exp_bd = 1'b1;
`else
        exp_epc = 32'h0000_3008; exp_bd = 1'b0;
`endif
        M_exccode = 5'd10; M_bd = 1'b1; M_pc = 32'h0000_3008;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            errors++; $display("FAIL bd_req: got %b want 1", Req);
        end
        tick();
        M_exccode = 5'd0; M_bd = 1'b0; A1 = 5'd13;
        #1;
        checks++;
        if (EPC_out !== exp_epc) begin
            errors++; $display("FAIL bd_epc: got %h want %h", EPC_out, exp_epc);
        end
        checks++;
        if (Dout[31] !== exp_bd || Dout[6:2] !== 5'd10) begin
            errors++; $display("FAIL bd_cause: got %h want bd=%b code=10", Dout, exp_bd);
        end
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_write_suppressed();
        M_exccode = 5'd4; M_pc = 32'h0000_3020;
        we = 1'b1; A2 = 5'd14; Din = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            errors++; $display("FAIL sup_req: got %b want 1", Req);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (EPC_out !== 32'h0000_3020) begin
            errors++; $display("FAIL sup_epc: got %h want 00003020", EPC_out);
        end
        checks++;
        if (Req !== 1'b0) begin
            errors++; $display("FAIL exl_masks_exc: got %b want 0", Req);
        end
        M_exccode = 5'd0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; A1 = 5'd12;
        #1;
        checks++;
        if (Dout[1] !== 1'b0) begin
            errors++; $display("FAIL eret_exl: got %b want 0", Dout[1]);
        end
    endtask

    task automatic test_mid_reset();
        M_exccode = 5'd6; M_pc = 32'h0000_3040;
        tick();
        M_exccode = 5'd3; reset = 1'b1;
        tick();
        reset = 1'b0; A1 = 5'd12;
        #1;
        checks++;
        if (Dout !== 32'd0 || EPC_out !== 32'd0) begin
            errors++; $display("FAIL midreset_state: got sr=%h epc=%h want 0 0", Dout, EPC_out);
        end
        checks++;
        if (Req !== 1'b1) begin
            errors++; $display("FAIL midreset_req: got %b want 1", Req);
        end
        tick();
        M_exccode = 5'd0;
        mtc0(5'd12, 32'd0);
    endtask

    task automatic test_random();
        logic [4:0] regs[5];
        regs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 39) == 0);
            we        = ($urandom_range(0, 3) == 0);
            A2        = regs[$urandom_range(0, 4)];
            Din       = $urandom;
            A1        = 5'($urandom_range(10, 17));
            M_pc      = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            M_bd      = 1'($urandom_range(0, 1));
            M_exccode = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            HWInt     = 6'($urandom_range(0, 63));
            EXLClr    = ($urandom_range(0, 5) == 0);
            #1;
            checks++;
            if (Req !== model_req()) begin
                errors++; $display("FAIL rand_req[%0d]: got %b want %b", n, Req, model_req());
            end
            checks++;
            if (Dout !== model_read(A1)) begin
                errors++;
                $display("FAIL rand_dout[%0d] a1=%0d: got %h want %h", n, A1, Dout, model_read(A1));
            end
            checks++;
            if (EPC_out !== m_epc) begin
                errors++; $display("FAIL rand_epc[%0d]: got %h want %h", n, EPC_out, m_epc);
            end
            tick();
        end
        idle_inputs();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_sr_exl_clear();
        test_int_priority();
        test_branch_delay();
        test_write_suppressed();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
